// File: rtl/aes_pkg.sv
// Shared AES definitions: state geometry, GF(2^8) constants and arithmetic
// helpers used by both the forward and inverse column mixers.
package aes_pkg;

   localparam int WORD = 32;
   localparam int NB   = 4;

   localparam logic [7:0] GF_09 = 8'h09;
   localparam logic [7:0] GF_0B = 8'h0b;
   localparam logic [7:0] GF_0D = 8'h0d;
   localparam logic [7:0] GF_0E = 8'h0e;

   // low byte of the reduction polynomial 0x11B
   localparam logic [7:0] GF_POLY = 8'h1b;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } imc_state_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
   endfunction

   // shift-and-add multiply; constant operands fold down to a few XORs
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] sh;
      acc = 8'h00;
      sh  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = xtime(sh);
      end
      return acc;
   endfunction

endpackage

// File: rtl/inv_mapcolumn.sv
// Combinational InvMixColumns on one 4-byte state column (row 0 = MSB byte).
module inv_mapcolumn #(
   parameter int WORD = aes_pkg::WORD
) (
   input  logic [WORD-1:0] col_i,
   output logic [WORD-1:0] col_o
);
   import aes_pkg::*;

   localparam int ROWS = 4;

   logic [7:0] a [ROWS];
   logic [7:0] r [ROWS];

   // split column into bytes, apply the 0e/0b/0d/09 circulant, repack
   always_comb begin
      col_o = '0;
      for (int i = 0; i < ROWS; i++) begin
         a[i] = col_i[WORD-1-8*i -: 8];
      end
      for (int i = 0; i < ROWS; i++) begin
         r[i] = gf_mul(a[i], GF_0E)
              ^ gf_mul(a[(i+1)%ROWS], GF_0B)
              ^ gf_mul(a[(i+2)%ROWS], GF_0D)
              ^ gf_mul(a[(i+3)%ROWS], GF_09);
         col_o[WORD-1-8*i -: 8] = r[i];
      end
   end

endmodule

// File: rtl/inv_mixcolumns_serial.sv
// Column-serial InvMixColumns: captures a block, transforms one column per
// cycle through a single inv_mapcolumn, then holds the result until taken.
//
// state | meaning
// IDLE  | waiting for a block, i_ready high
// BUSY  | writing column cnt of the result each cycle
// DONE  | result valid, holding until o_ready
module inv_mixcolumns_serial #(
   parameter int WORD = aes_pkg::WORD,
   parameter int NB   = aes_pkg::NB
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_valid,
   output logic               i_ready,
   input  logic [WORD*NB-1:0] i_block,
   output logic               o_valid,
   input  logic               o_ready,
   output logic [WORD*NB-1:0] o_block
);
   import aes_pkg::*;

   localparam int CW = (NB > 1) ? $clog2(NB) : 1;

   imc_state_e         state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WORD*NB-1:0] cap_q, cap_d;
   logic [WORD*NB-1:0] oblk_q, oblk_d;
   logic               ovalid_q, ovalid_d;

   logic [WORD-1:0]    col_in;
   logic [WORD-1:0]    col_out;

   // select the captured column addressed by the counter
   always_comb begin
      col_in = '0;
      for (int c = 0; c < NB; c++) begin
         if (cnt_q == CW'(c)) col_in = cap_q[WORD*(NB-c)-1 -: WORD];
      end
   end

   inv_mapcolumn #(.WORD(WORD)) u_map (
      .col_i (col_in),
      .col_o (col_out)
   );

   // next-state, counter, capture and output-column update
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      cap_d    = cap_q;
      oblk_d   = oblk_q;
      ovalid_d = ovalid_q;
      case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               cap_d   = i_block;
               cnt_d   = '0;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            for (int c = 0; c < NB; c++) begin
               if (cnt_q == CW'(c)) oblk_d[WORD*(NB-c)-1 -: WORD] = col_out;
            end
            if (cnt_q == CW'(NB-1)) begin
               cnt_d    = '0;
               ovalid_d = 1'b1;
               state_d  = ST_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DONE: begin
            if (o_ready) begin
               ovalid_d = 1'b0;
               state_d  = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // state registers; reset overrides acceptance and handshake
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         cap_q    <= '0;
         oblk_q   <= '0;
         ovalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         cap_q    <= cap_d;
         oblk_q   <= oblk_d;
         ovalid_q <= ovalid_d;
      end
   end

   assign i_ready = (state_q == ST_IDLE);
   assign o_valid = ovalid_q;
   assign o_block = oblk_q;

endmodule

// File: tb/tb_inv_mixcolumns_serial.sv
// Directed bench for inv_mixcolumns_serial plus a forward-mix round trip.
module tb_inv_mixcolumns_serial;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_valid;
   logic         i_ready;
   logic [127:0] i_block;
   logic         o_valid;
   logic         o_ready;
   logic [127:0] o_block;

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
   localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
   localparam logic [127:0] V2_IN  = 128'h4d7ebdf8_d5d5d7d6_00000000_ffffffff;
   localparam logic [127:0] V2_OUT = 128'h2d26314c_d4d4d4d5_00000000_ffffffff;

   inv_mixcolumns_serial dut (
      .clk     (clk),
      .rst     (rst),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .i_block (i_block),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_block (o_block)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // forward MixColumns, used to build round-trip stimulus
   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24]; a1 = c[23:16]; a2 = c[15:8]; a3 = c[7:0];
      return { xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
               a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
               a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
               xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3) };
   endfunction

   function automatic logic [127:0] mix_blk(input logic [127:0] b);
      return {mix_col(b[127:96]), mix_col(b[95:64]), mix_col(b[63:32]), mix_col(b[31:0])};
   endfunction

   initial begin
      logic [127:0] orig;
      int           t;
      int           acc;
      bit           got;

      rst = 1'b0; i_valid = 1'b0; i_block = '0; o_ready = 1'b0;
      tick(); tick();
      chk("rst_ovalid", {127'b0, o_valid}, 128'd0);
      chk("rst_oblock", o_block, 128'd0);
      rst = 1'b1;
      tick();
      chk("rel_iready", {127'b0, i_ready}, 128'd1);

      // single block, o_ready high
      o_ready = 1'b1; i_valid = 1'b1; i_block = V1_IN;
      tick();
      i_valid = 1'b0;
      chk("v1_busy_iready", {127'b0, i_ready}, 128'd0);
      for (int k = 1; k < 4; k++) begin
         chk("v1_early_ovalid", {127'b0, o_valid}, 128'd0);
         tick();
      end
      tick();
      chk("v1_ovalid", {127'b0, o_valid}, 128'd1);
      chk("v1_oblock", o_block, V1_OUT);
      tick();
      chk("v1_ovalid_pulse", {127'b0, o_valid}, 128'd0);
      chk("v1_iready_back", {127'b0, i_ready}, 128'd1);

      // backpressure
      o_ready = 1'b0; i_valid = 1'b1; i_block = V2_IN;
      tick();
      i_valid = 1'b0;
      tick(); tick(); tick(); tick();
      for (int k = 0; k < 10; k++) begin
         chk("bp_ovalid", {127'b0, o_valid}, 128'd1);
         chk("bp_oblock", o_block, V2_OUT);
         chk("bp_iready", {127'b0, i_ready}, 128'd0);
         tick();
      end
      o_ready = 1'b1;
      tick();
      o_ready = 1'b0;
      chk("bp_release_ovalid", {127'b0, o_valid}, 128'd0);
      chk("bp_release_iready", {127'b0, i_ready}, 128'd1);
      chk("bp_hold_oblock", o_block, V2_OUT);

      // input churn while busy/done, then o_ready with i_valid in DONE
      i_valid = 1'b1; i_block = V1_IN;
      tick();
      for (int k = 0; k < 7; k++) begin
         i_block = {$urandom, $urandom, $urandom, $urandom};
         if (k < 4) chk("churn_iready", {127'b0, i_ready}, 128'd0);
         tick();
      end
      chk("churn_ovalid", {127'b0, o_valid}, 128'd1);
      chk("churn_oblock", o_block, V1_OUT);
      o_ready = 1'b1;
      tick();
      i_valid = 1'b0; o_ready = 1'b0;
      chk("done_noaccept_iready", {127'b0, i_ready}, 128'd1);
      chk("done_noaccept_ovalid", {127'b0, o_valid}, 128'd0);
      tick();
      chk("done_still_idle", {127'b0, i_ready}, 128'd1);

      // reset in BUSY at cnt=2
      i_valid = 1'b1; i_block = V2_IN; o_ready = 1'b1;
      tick();
      i_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("midrst_ovalid", {127'b0, o_valid}, 128'd0);
      chk("midrst_oblock", o_block, 128'd0);
      chk("midrst_iready", {127'b0, i_ready}, 128'd1);
      acc = 0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (o_valid) acc++;
      end
      chk("midrst_no_ovalid", 128'(acc), 128'd0);

      // reset on the acceptance edge
      rst = 1'b0; i_valid = 1'b1; i_block = V1_IN;
      tick();
      rst = 1'b1; i_valid = 1'b0;
      chk("rstacc_iready", {127'b0, i_ready}, 128'd1);
      acc = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (o_valid || !i_ready) acc++;
      end
      chk("rstacc_no_block", 128'(acc), 128'd0);

      // throughput: i_valid and o_ready held high for 60 cycles
      i_valid = 1'b1; o_ready = 1'b1; i_block = V2_IN; acc = 0;
      for (int k = 0; k < 60; k++) begin
         if (i_ready) acc++;
         tick();
      end
      chk("throughput_blocks", 128'(acc), 128'd10);
      i_valid = 1'b0;
      t = 0;
      while (!i_ready && t < 20) begin tick(); t++; end
      chk("throughput_drain", {127'b0, i_ready}, 128'd1);

      // round trip through forward mix with random backpressure
      for (int n = 0; n < 1000; n++) begin
         orig = {$urandom, $urandom, $urandom, $urandom};
         chk("rt_iready", {127'b0, i_ready}, 128'd1);
         i_valid = 1'b1; i_block = mix_blk(orig); o_ready = 1'($urandom_range(0, 1));
         tick();
         i_valid = 1'b0;
         t = 0; got = 1'b0;
         while (!got && t < 100) begin
            o_ready = 1'($urandom_range(0, 1));
            if (o_valid && o_ready) begin
               chk("rt_oblock", o_block, orig);
               got = 1'b1;
            end
            tick();
            t++;
         end
         if (!got) chk("rt_timeout", 128'd0, 128'd1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/inv_mixcolumns_serial.md
INV_MIXCOLUMNS_SERIAL -- requirements
Module: inv_mixcolumns_serial

Interface
REQ-001 SHALL have parameter WORD, default 32, meaning bits per state column.
REQ-002 SHALL have parameter NB, default 4, meaning columns per block.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, a synchronous, active-low reset.
REQ-005 SHALL have port i_valid, input, 1, meaning the input block is offered.
REQ-006 SHALL have port i_ready, output, 1, meaning the block can accept input; combinational from state.
REQ-007 SHALL have port i_block, input, WORD*NB, the state block; column c sits at bits [WORD*(NB-c)-1 : WORD*(NB-c-1)]; row 0 is the MSB byte of each column.
REQ-008 SHALL have port o_valid, output, 1, meaning o_block is valid; registered.
REQ-009 SHALL have port o_ready, input, 1, meaning the downstream consumer accepts o_block.
REQ-010 SHALL have port o_block, output, WORD*NB, the InvMixColumns result with the same column and byte layout as i_block; registered.

Function
REQ-011 SHALL apply AES InvMixColumns per column over GF(2^8), reduction polynomial 0x11B; output row r = 0e*a[r] ^ 0b*a[r+1] ^ 0d*a[r+2] ^ 09*a[r+3], indices mod 4.
REQ-012 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-013 SHALL drive i_ready=1 only in IDLE.
REQ-014 SHALL treat i_valid&&i_ready at an edge as acceptance: capture i_block into an internal register, clear column counter to 0, go to BUSY.
REQ-015 SHALL ignore i_block and i_valid outside IDLE; later changes to i_block SHALL NOT affect the block in flight.
REQ-016 In BUSY, each edge SHALL write column cnt of the result into o_block and increment cnt, one column per cycle in order 0..NB-1.
REQ-017 SHALL go from BUSY to DONE and set o_valid=1 on the edge that writes column NB-1; o_valid therefore rises NB edges after the acceptance edge.
REQ-018 The counter SHALL be $clog2(NB) bits wide and wrap to 0 after NB-1.
REQ-019 In DONE, o_valid and o_block SHALL hold stable while o_ready=0, for any number of cycles.
REQ-020 In DONE with o_ready=1, the block SHALL clear o_valid and return to IDLE on that edge; no new input is accepted on the same edge.
REQ-021 Throughput: at most one block per NB+2 cycles with o_ready tied high.
REQ-022 o_block bits SHALL change only in BUSY column writes or on reset.
REQ-023 o_ready SHALL be ignored outside DONE.

Reset
REQ-024 When rst=0 at an edge, the block SHALL set state=IDLE, cnt=0, o_valid=0, o_block=0 and the capture register=0.
REQ-025 Reset SHALL take priority over all other events, including acceptance and handshake on the same edge.
REQ-026 Reset during BUSY or DONE SHALL discard the block in flight; no o_valid pulse follows.
REQ-027 i_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-028 WORD, NB and the GF multiply constants 0x09, 0x0B, 0x0D, 0x0E SHALL live in shared package aes_pkg; the xtime/gf_mul functions SHALL also live there for reuse by the forward cipher.
REQ-029 The per-column transform SHALL be one combinational sub-module, inv_mapcolumn (WORD-bit in, WORD-bit out); a single instance SHALL be muxed by cnt.

Verification
REQ-030 Single block: i_block=8e4da1bc_9fdc589d_01010101_c6c6c6c6, o_ready=1 -> o_block=db135345_f20a225c_01010101_c6c6c6c6, with o_valid high exactly one cycle, NB edges after acceptance.
REQ-031 Backpressure: i_block=4d7ebdf8_d5d5d7d6_00000000_ffffffff, o_ready=0 for 10 cycles -> o_block=2d26314c_d4d4d4d5_00000000_ffffffff held stable, i_ready=0 throughout; one-cycle o_ready then gives i_ready=1 the next cycle.
REQ-032 Input churn: randomise i_block and i_valid=1 while BUSY/DONE -> result equals the transform of the captured block only; no second acceptance until IDLE.
REQ-033 Reset mid-BUSY: assert rst=0 at cnt=2 -> next cycle o_valid=0, o_block=0, i_ready=1; no spurious o_valid afterwards.
REQ-034 Round-trip: 1000 random blocks through the existing mixcolumns then inv_mixcolumns_serial, with random o_ready -> every output equals the original block; throughput is NB+2 cycles per block when o_ready=1.
REQ-035 Simultaneous events: rst=0 on the same edge as acceptance, and o_ready=1 on the same edge as i_valid=1 in DONE -> reset wins, and no acceptance occurs in DONE.
